// File: rtl/ofdmbbp_rx_cmd_sched.sv
// OFDM baseband RX command scheduler.
// Pops packed command words from the command FIFO, hands each one to the RX
// core over a valid/ready handshake, counts the core's output words until the
// command completes, then waits out the command's pause interval. It also
// keeps a retired-command counter and two sticky error flags.
module ofdmbbp_rx_cmd_sched #(
    parameter int LEN_W   = 8,
    parameter int PAUSE_W = 22,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clr_err,
    input  logic               cmdq_empty,
    output logic               cmdq_rd,
    input  logic [31:0]        cmdq_dout,
    input  logic               dataq_full,
    output logic               rx_cmd_valid,
    input  logic               rx_cmd_ready,
    output logic [LEN_W-1:0]   rx_cmd_length,
    output logic [1:0]         rx_cmd_mode,
    output logic [PAUSE_W-1:0] rx_cmd_pause,
    input  logic               rx_dout_valid,
    output logic               busy,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   done_cnt,
    output logic               err_ovf,
    output logic               err_stray
);

    // Word counter is one bit wider than the length field so that a length
    // of 0 can stand for the full 2^LEN_W words.
    localparam int WC_W = LEN_W + 1;
    localparam logic [WC_W-1:0] FULL_CNT = {1'b1, {LEN_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        ISSUE = 3'd3,
        RUN   = 3'd4,
        PAUSE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic [PAUSE_W-1:0] pause_q, pause_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [PAUSE_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   done_q, done_d;

    // Fields of the command word as presented by the FIFO during LATCH.
    logic [LEN_W-1:0]   cmd_len;
    logic [1:0]         cmd_mode;
    logic [PAUSE_W-1:0] cmd_pause;
    logic [WC_W-1:0]    target;
    logic [WC_W-1:0]    wcnt_inc;

    assign cmd_len   = cmdq_dout[LEN_W-1:0];
    assign cmd_mode  = cmdq_dout[LEN_W+1:LEN_W];
    assign cmd_pause = cmdq_dout[LEN_W+2+PAUSE_W-1:LEN_W+2];
    assign target    = (len_q == '0) ? FULL_CNT : {1'b0, len_q};
    assign wcnt_inc  = wcnt_q + WC_W'(1);

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        pause_d = pause_q;
        wcnt_d  = wcnt_q;
        pcnt_d  = pcnt_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (enable && !cmdq_empty && !dataq_full) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                len_d   = cmd_len;
                mode_d  = cmd_mode;
                pause_d = cmd_pause;
                if (cmd_mode == 2'd3) begin
                    // Pause-only command: nothing goes to the core.
                    done_d = done_q + CNT_W'(1);
                    if (cmd_pause != '0) begin
                        pcnt_d  = cmd_pause;
                        state_d = PAUSE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rx_cmd_ready) begin
                    wcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rx_dout_valid) begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == target) begin
                        done_d = done_q + CNT_W'(1);
                        if (pause_q != '0) begin
                            pcnt_d  = pause_q;
                            state_d = PAUSE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            PAUSE: begin
                // Leaving on the count of 1 gives exactly 'pause' cycles here;
                // a zero count is treated the same so the state cannot stick.
                if (pcnt_q <= PAUSE_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q - PAUSE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            mode_q  <= '0;
            pause_q <= '0;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            pause_q <= pause_d;
            wcnt_q  <= wcnt_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
        end
    end

    // Sticky error events: bit 0 overflow, bit 1 stray output word.
    logic [1:0] err_set;
    logic [1:0] err_flags;

    assign err_set[0] = rx_dout_valid && dataq_full;
    assign err_set[1] = rx_dout_valid && (state_q != RUN);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_err
            logic flag_q;
            // A new event wins over a coincident clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    flag_q <= 1'b0;
                end else begin
                    flag_q <= err_set[gi] | (flag_q & ~clr_err);
                end
            end
            assign err_flags[gi] = flag_q;
        end
    endgenerate

    // All outputs come straight from registers or decoded registered state.
    assign cmdq_rd       = (state_q == FETCH);
    assign rx_cmd_valid  = (state_q == ISSUE);
    assign rx_cmd_length = len_q;
    assign rx_cmd_mode   = mode_q;
    assign rx_cmd_pause  = '0;
    assign busy          = (state_q != IDLE);
    assign state         = state_q;
    assign done_cnt      = done_q;
    assign err_ovf       = err_flags[0];
    assign err_stray     = err_flags[1];

endmodule

// File: tb/tb_ofdmbbp_rx_cmd_sched.sv
// Testbench for ofdmbbp_rx_cmd_sched: directed scenarios followed by random
// commands, all checked against expectations derived from the command fields.
module tb_ofdmbbp_rx_cmd_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clr_err;
    logic        cmdq_empty;
    logic        cmdq_rd;
    logic [31:0] cmdq_dout;
    logic        dataq_full;
    logic        rx_cmd_valid;
    logic        rx_cmd_ready;
    logic [7:0]  rx_cmd_length;
    logic [1:0]  rx_cmd_mode;
    logic [21:0] rx_cmd_pause;
    logic        rx_dout_valid;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] done_cnt;
    logic        err_ovf;
    logic        err_stray;

    int errors = 0;
    int checks = 0;
    int exp_done = 0;
    int exp_pops = 0;
    int rd_pulses = 0;

    ofdmbbp_rx_cmd_sched #(.LEN_W(8), .PAUSE_W(22), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .clr_err       (clr_err),
        .cmdq_empty    (cmdq_empty),
        .cmdq_rd       (cmdq_rd),
        .cmdq_dout     (cmdq_dout),
        .dataq_full    (dataq_full),
        .rx_cmd_valid  (rx_cmd_valid),
        .rx_cmd_ready  (rx_cmd_ready),
        .rx_cmd_length (rx_cmd_length),
        .rx_cmd_mode   (rx_cmd_mode),
        .rx_cmd_pause  (rx_cmd_pause),
        .rx_dout_valid (rx_dout_valid),
        .busy          (busy),
        .state         (state),
        .done_cnt      (done_cnt),
        .err_ovf       (err_ovf),
        .err_stray     (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-read command FIFO model: data appears the cycle after the strobe.
    logic [31:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign cmdq_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (cmdq_rd === 1'b1 && rd_ptr != wr_ptr) begin
            cmdq_dout <= fifo_mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Count every cycle the read strobe is seen high.
    always @(negedge clk) begin
        if (cmdq_rd === 1'b1) rd_pulses <= rd_pulses + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {state, cmdq_rd, rx_cmd_valid, rx_cmd_length, rx_cmd_mode, rx_cmd_pause,
                  busy, done_cnt, err_ovf, err_stray}, 64'd0);
    endtask

    // Runs one command from the IDLE sample point to the IDLE sample after it.
    task automatic run_cmd(input logic [31:0] w, input bit do_push, input int rdy_dly,
                           input bit full_run, input bit drop_en);
        int len, mode, pause, target, pc;
        logic [2:0] exp_st;
        len    = int'(w[7:0]);
        mode   = int'(w[9:8]);
        pause  = int'(w[31:10]);
        target = (len == 0) ? 256 : len;
        exp_st = (pause != 0) ? 3'd5 : 3'd0;
        if (do_push) push(w);
        exp_pops++;
        step();
        chk("fetch", {state, cmdq_rd}, {3'd1, 1'b1});
        step();
        chk("latch", {state, cmdq_rd, rx_cmd_valid}, {3'd2, 2'b00});
        step();
        if (mode == 3) begin
            exp_done++;
            chk("pausecmd_retire", {state, rx_cmd_valid, done_cnt}, {exp_st, 1'b0, 16'(exp_done)});
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                chk("issue_hold", {state, rx_cmd_valid, rx_cmd_length, rx_cmd_mode, rx_cmd_pause},
                    {3'd3, 1'b1, w[7:0], w[9:8], 22'd0});
                step();
            end
            chk("issue", {state, rx_cmd_valid, rx_cmd_length, rx_cmd_mode, rx_cmd_pause},
                {3'd3, 1'b1, w[7:0], w[9:8], 22'd0});
            rx_cmd_ready = 1'b1;
            step();
            rx_cmd_ready = 1'b0;
            chk("run_entry", {state, rx_cmd_valid}, {3'd4, 1'b0});
            if (drop_en) enable = 1'b0;
            if (full_run) dataq_full = 1'b1;
            for (int k = 1; k <= target; k++) begin
                if (k == target) chk("pre_retire", {state, done_cnt}, {3'd4, 16'(exp_done)});
                rx_dout_valid = 1'b1;
                step();
                rx_dout_valid = 1'b0;
                if (k < target) repeat ($urandom_range(0, 2)) step();
            end
            dataq_full = 1'b0;
            exp_done++;
            chk("retire", {state, done_cnt}, {exp_st, 16'(exp_done)});
        end
        pc = 0;
        while (state === 3'd5 && pc < 10000) begin
            pc++;
            step();
        end
        chk("pause_len", pc, pause);
        chk("idle_after", {state, busy}, {3'd0, 1'b0});
        $display("cmd word=%08h len=%0d mode=%0d pause=%0d done_cnt=%0d", w, len, mode, pause, done_cnt);
    endtask

    task automatic hold_idle(input string tag, input int n);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (cmdq_rd !== 1'b0 || state !== 3'd0) bad = 1'b1;
        end
        chk(tag, bad, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        bit stray_bad;
        rst = 1'b1;
        enable = 1'b0;
        clr_err = 1'b0;
        dataq_full = 1'b0;
        rx_cmd_ready = 1'b0;
        rx_dout_valid = 1'b0;
        cmdq_dout = 32'd0;
        @(negedge clk);
        step();
        chk_reset("reset_values");
        rst = 1'b0;
        enable = 1'b1;
        step();
        chk_reset("after_reset_release");

        // Single command: mode 1, length 16, no pause.
        run_cmd(32'h0000_0110, 1'b1, 0, 1'b0, 1'b0);
        chk("single_rd_once", rd_pulses, 1);

        // Pause timing with a second command already queued.
        push({22'd5, 2'd1, 8'd4});
        push({22'd0, 2'd2, 8'd3});
        run_cmd({22'd5, 2'd1, 8'd4}, 1'b0, 0, 1'b0, 1'b0);
        run_cmd({22'd0, 2'd2, 8'd3}, 1'b0, 0, 1'b0, 1'b0);

        // Length 0 (256 words) with the handshake held off for 10 cycles.
        run_cmd({22'd2, 2'd0, 8'd0}, 1'b1, 10, 1'b0, 1'b0);

        // Pause-only commands, with and without a pause.
        run_cmd({22'd3, 2'd3, 8'd9}, 1'b1, 0, 1'b0, 1'b0);
        run_cmd({22'd0, 2'd3, 8'd0}, 1'b1, 0, 1'b0, 1'b0);

        // Sticky error flags in IDLE.
        rx_dout_valid = 1'b1;
        step();
        rx_dout_valid = 1'b0;
        chk("stray_set", {err_ovf, err_stray, state, done_cnt}, {2'b01, 3'd0, 16'(exp_done)});
        clr_err = 1'b1;
        rx_dout_valid = 1'b1;
        step();
        rx_dout_valid = 1'b0;
        chk("stray_set_wins", {err_ovf, err_stray}, 2'b01);
        step();
        clr_err = 1'b0;
        chk("stray_cleared", {err_ovf, err_stray}, 2'b00);
        dataq_full = 1'b1;
        rx_dout_valid = 1'b1;
        step();
        rx_dout_valid = 1'b0;
        dataq_full = 1'b0;
        chk("ovf_set", {err_ovf, err_stray}, 2'b11);
        step();
        chk("ovf_sticky", {err_ovf, err_stray}, 2'b11);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_cleared", {err_ovf, err_stray}, 2'b00);

        // Output FIFO full during RUN: no stall, overflow flagged, no stray.
        run_cmd({22'd1, 2'd1, 8'd5}, 1'b1, 2, 1'b1, 1'b0);
        chk("run_full_flags", {err_ovf, err_stray}, 2'b10);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Gating in IDLE by dataq_full and by enable.
        w = {22'd0, 2'd1, 8'd2};
        dataq_full = 1'b1;
        push(w);
        hold_idle("gate_full", 6);
        dataq_full = 1'b0;
        enable = 1'b0;
        hold_idle("gate_enable", 6);
        enable = 1'b1;
        run_cmd(w, 1'b0, 0, 1'b0, 1'b0);

        // enable dropped during RUN: command and pause still complete.
        run_cmd({22'd4, 2'd2, 8'd6}, 1'b1, 1, 1'b0, 1'b1);
        w = {22'd0, 2'd0, 8'd1};
        push(w);
        hold_idle("hold_after_disable", 5);
        enable = 1'b1;
        run_cmd(w, 1'b0, 0, 1'b0, 1'b0);

        // Random commands.
        stray_bad = 1'b0;
        for (int n = 0; n < 25; n++) begin
            logic [7:0]  rl;
            logic [1:0]  rm;
            logic [21:0] rp;
            rl = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            rm = 2'($urandom_range(0, 3));
            rp = ($urandom_range(0, 2) == 0) ? 22'd0 : 22'($urandom_range(1, 12));
            run_cmd({rp, rm, rl}, 1'b1, $urandom_range(0, 4), 1'b0, 1'b0);
            if (err_stray !== 1'b0 || err_ovf !== 1'b0) stray_bad = 1'b1;
        end
        chk("random_no_errors", stray_bad, 1'b0);
        chk("read_strobe_count", rd_pulses, exp_pops);

        // Asynchronous reset in the middle of RUN.
        push({22'd0, 2'd1, 8'd20});
        rx_cmd_ready = 1'b1;
        repeat (4) step();
        rx_cmd_ready = 1'b0;
        chk("rst_test_in_run", state, 3'd4);
        repeat (3) begin
            rx_dout_valid = 1'b1;
            step();
        end
        rx_dout_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset("async_reset_in_run");
        $display("async reset asserted mid-RUN, state=%0d done_cnt=%0d", state, done_cnt);
        step();
        rst = 1'b0;
        exp_done = 0;
        step();
        chk_reset("reset_holds");
        run_cmd({22'd2, 2'd1, 8'd3}, 1'b1, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
